native_in_stream_packer: RTL and testbench
==========================================

// Module: native_in_stream_packer
// PURPOSE
//  Consumes the video-capture alignment pulses (falign/lalign/ealign) and native pixel stream from the
//  capture front end and converts them into an AXI4-Stream master for the VDMA write channel.
//  tuser marks the first pixel of a frame and tlast marks the last pixel of a line.
//  A small FIFO absorbs tready back-pressure, because the video source cannot stall.
//  The block flags overflow and line-length errors.
// PARAMETERS
//  DSIZE       24   pixel width, bits
//  FIFO_DEPTH  16   output FIFO entries; power of 2, >=4
// PORTS
//  clock          in   1      system clock
//  rst_n          in   1      asynchronous active-low reset
//  hactive        in   16     expected pixels per line; 0 disables the length check
//  falign         in   1      1-cycle pulse: frame start, arrives before the first pixel of a frame
//  lalign         in   1      1-cycle pulse: line end, arrives after the last pixel and before the next line
//  ealign         in   1      1-cycle pulse: frame end, arrives after the last line
//  idata_vld      in   1      pixel valid
//  idata          in   DSIZE  pixel data
//  m_axis_tdata   out  DSIZE  stream data
//  m_axis_tvalid  out  1      stream valid
//  m_axis_tready  in   1      stream ready
//  m_axis_tuser   out  1      start of frame, first beat only
//  m_axis_tlast   out  1      end of line
//  frame_done     out  1      1-cycle pulse
//  overflow       out  1      sticky: at least one beat was dropped
//  line_len_err   out  1      sticky: a closed line had a pixel count different from hactive
// BEHAVIOUR
//  - Reset values: all outputs 0. FIFO empty, pending register invalid, all flags 0.
//    rst_n asserted mid-frame discards the pending pixel and the FIFO contents immediately.
//  - Pending register: holds {pend_vld, pend_sof, pend_data}. The block cannot know a pixel is last in its line
//    until lalign arrives, so every pixel waits in this register.
//  - sof_flag:
//    - set by falign;
//    - copied into pend_sof when the next pixel is loaded into the pending register;
//    - cleared by that load.
//    - falign and idata_vld in the same cycle: that pixel gets pend_sof=1.
//  - Per cycle, at most one FIFO push, with this priority:
//    a) falign & pend_vld (line never closed): push {sof=pend_sof, last=1}. Set line_len_err.
//    b) lalign & pend_vld: push {pend_sof, last=1}.
//    c) idata_vld & pend_vld: push {pend_sof, last=0}.
//    Whenever idata_vld=1 the new pixel loads into the pending register, otherwise pend_vld clears after a or b.
//  - lalign with pend_vld=0 (empty line): ignored, no push, pixel counter unchanged.
//  - Pixel counter:
//    - pix_cnt[15:0] increments on each pixel loaded.
//    - When a line closes (case a or b): if hactive!=0 and count!=hactive, set line_len_err.
//    - pix_cnt reloads to 1 if a pixel loads in the same cycle, else 0.
//    - Saturates at 16'hFFFF.
//  - Push while FIFO full: the entry is dropped and overflow is set; the FIFO is not modified.
//    overflow and line_len_err clear only on reset.
//  - Output: first-word-fallthrough.
//    - m_axis_tvalid = !empty.
//    - tdata/tuser/tlast are stable while tvalid & !tready.
//    - Pop on tvalid & tready.
//    - Push and pop in the same cycle while full: the pop frees space and the push is accepted.
//  - Latency: pixel N enters the FIFO on the cycle that pixel N+1 (or lalign) arrives.
//    It is visible on m_axis one cycle later.
//  - frame_done: registered copy of ealign, 1 cycle later. It does not wait for the FIFO to drain.
//  - Width rules:
//    - FIFO entry = DSIZE+2 bits, laid out {tuser, tlast, data}.
//    - Pointers are clog2(FIFO_DEPTH)+1 bits; full/empty are decided by the extra MSB.
// STRUCTURE
//  - Shared package vdma_pkg:
//    - clog2 function;
//    - entry field positions FLD_USER=DSIZE+1, FLD_LAST=DSIZE;
//    - default FIFO_DEPTH.
//  - Sub-module vdma_sync_fifo_fwft (WIDTH, DEPTH): single-clock FWFT FIFO with full, empty and level outputs.
//  - The top level contains the pending register, sof_flag, pixel counter, push arbitration, flags and frame_done.
// TESTING
//  1. hactive=4, falign, 2 lines of 4 pixels 0x000001..8, tready=1
//     -> 8 beats; tuser only on 0x000001; tlast on 0x000004 and 0x000008; no flags set.
//  2. Same stimulus, tready=0 for 20 cycles, FIFO_DEPTH=4
//     -> overflow=1; the 4 oldest beats come out in order after tready=1; tvalid/tdata held stable while stalled.
//  3. falign and first idata_vld in the same cycle, then lalign and the next line's first pixel in the same cycle
//     -> tuser on that first pixel; tlast on the previous pixel; nothing lost.
//  4. Line of 3 pixels with hactive=4 -> line_len_err=1; the beats themselves are still correct.
//  5. falign arrives with a pixel still pending
//     -> that pixel is emitted with tlast=1 and line_len_err=1; the next frame's first pixel has tuser=1.
//  6. rst_n pulsed low mid-line with a non-empty FIFO
//     -> tvalid=0 asynchronously; flags cleared; the next frame streams cleanly; ealign -> frame_done 1 cycle later.

Source files
------------

// File: rtl/vdma_pkg.sv
// Shared definitions for the VDMA capture path: FIFO entry layout,
// default sizes and a constant clog2 helper.
package vdma_pkg;

    localparam int DEF_DSIZE      = 24;
    localparam int DEF_FIFO_DEPTH = 16;

    // Entry layout is {tuser, tlast, data}
    localparam int FLD_USER = DEF_DSIZE + 1;
    localparam int FLD_LAST = DEF_DSIZE;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int fld_user(input int dsize);
        return dsize + 1;
    endfunction

    function automatic int fld_last(input int dsize);
        return dsize;
    endfunction

endpackage

// File: rtl/vdma_sync_fifo_fwft.sv
// Single-clock first-word-fallthrough FIFO. Pointers carry one extra
// MSB so full and empty are distinguished without a separate counter.
module vdma_sync_fifo_fwft
    import vdma_pkg::*;
#(
    parameter int WIDTH = 26,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    // A pop in the same cycle frees the slot a push to a full FIFO needs
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/native_in_stream_packer.sv
// Turns aligned native pixel stream into AXI4-Stream with tuser/tlast,
// buffering through a FWFT FIFO and flagging overflow and length errors.
module native_in_stream_packer
    import vdma_pkg::*;
#(
    parameter int DSIZE      = DEF_DSIZE,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [15:0]      hactive,
    input  logic             falign,
    input  logic             lalign,
    input  logic             ealign,
    input  logic             idata_vld,
    input  logic [DSIZE-1:0] idata,
    output logic [DSIZE-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic             frame_done,
    output logic             overflow,
    output logic             line_len_err
);

    localparam int EW     = DSIZE + 2;
    localparam int F_USER = fld_user(DSIZE);
    localparam int F_LAST = fld_last(DSIZE);
    localparam int LW     = clog2(FIFO_DEPTH) + 1;

    logic             pend_vld_q, pend_vld_d;
    logic             pend_sof_q, pend_sof_d;
    logic [DSIZE-1:0] pend_data_q, pend_data_d;
    logic             sof_flag_q, sof_flag_d;
    logic [15:0]      pix_cnt_q, pix_cnt_d;
    logic             overflow_q, overflow_d;
    logic             len_err_q, len_err_d;
    logic             frame_done_q, frame_done_d;

    logic             push, push_last, close;
    logic [EW-1:0]    push_entry;
    logic [EW-1:0]    pop_entry;
    logic             pop, drop;
    logic             fifo_full, fifo_empty;
    logic [LW-1:0]    fifo_level;
    logic             unused_level;

    // A pending pixel is only known to be last when a line/frame marker shows up
    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        close     = 1'b0;
        if (pend_vld_q && (falign || lalign)) begin
            push      = 1'b1;
            push_last = 1'b1;
            close     = 1'b1;
        end else if (pend_vld_q && idata_vld) begin
            push      = 1'b1;
        end
    end

    always_comb begin
        push_entry                = '0;
        push_entry[F_USER]        = pend_sof_q;
        push_entry[F_LAST]        = push_last;
        push_entry[DSIZE-1:0]     = pend_data_q;
    end

    assign pop  = !fifo_empty && m_axis_tready;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_sof_d  = pend_sof_q;
        pend_data_d = pend_data_q;
        if (idata_vld) begin
            pend_vld_d  = 1'b1;
            pend_sof_d  = sof_flag_q | falign;
            pend_data_d = idata;
        end else if (close) begin
            pend_vld_d  = 1'b0;
        end
        sof_flag_d = idata_vld ? 1'b0 : (sof_flag_q | falign);
    end

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (close) begin
            pix_cnt_d = {15'd0, idata_vld};
        end else if (idata_vld && pix_cnt_q != 16'hFFFF) begin
            pix_cnt_d = pix_cnt_q + 16'd1;
        end
    end

    // A frame start closing an open line is always a length error
    always_comb begin
        len_err_d = len_err_q;
        if (close && falign) begin
            len_err_d = 1'b1;
        end
        if (close && hactive != 16'd0 && pix_cnt_q != hactive) begin
            len_err_d = 1'b1;
        end
        overflow_d   = overflow_q | drop;
        frame_done_d = ealign;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q   <= 1'b0;
            pend_sof_q   <= 1'b0;
            pend_data_q  <= '0;
            sof_flag_q   <= 1'b0;
            pix_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            len_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pend_vld_q   <= pend_vld_d;
            pend_sof_q   <= pend_sof_d;
            pend_data_q  <= pend_data_d;
            sof_flag_q   <= sof_flag_d;
            pix_cnt_q    <= pix_cnt_d;
            overflow_q   <= overflow_d;
            len_err_q    <= len_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    vdma_sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_entry),
        .rd_en   (m_axis_tready),
        .rd_data (pop_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign unused_level = ^fifo_level;

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = pop_entry[DSIZE-1:0];
    assign m_axis_tuser  = pop_entry[F_USER];
    assign m_axis_tlast  = pop_entry[F_LAST];
    assign frame_done    = frame_done_q;
    assign overflow      = overflow_q;
    assign line_len_err  = len_err_q;

endmodule

// File: tb/tb_native_in_stream_packer.sv
// Bench for native_in_stream_packer: directed frames, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_native_in_stream_packer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] hactive = 16'd4;
    logic        falign = 1'b0;
    logic        lalign = 1'b0;
    logic        ealign = 1'b0;
    logic        idata_vld = 1'b0;
    logic [23:0] idata = '0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        frame_done;
    logic        overflow;
    logic        line_len_err;

    always #5 clock = ~clock;

    native_in_stream_packer #(
        .DSIZE      (24),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .hactive       (hactive),
        .falign        (falign),
        .lalign        (lalign),
        .ealign        (ealign),
        .idata_vld     (idata_vld),
        .idata         (idata),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .line_len_err  (line_len_err)
    );

    typedef struct {
        logic        u;
        logic        l;
        logic [23:0] d;
    } beat_t;

    typedef struct {
        logic        fa;
        logic        la;
        logic        v;
        logic [23:0] d;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: pixel waiting for its successor, the frame-start
    // mark, a pixel count and the output queue.
    logic        m_pv, m_ps, m_sf;
    logic [23:0] m_pd;
    int          m_cnt;
    beat_t       mq[$];
    logic        m_ovf, m_err, m_fd;
    beat_t       cap[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pv = 0; m_ps = 0; m_sf = 0; m_pd = '0; m_cnt = 0;
        mq.delete();
        m_ovf = 0; m_err = 0; m_fd = 0;
    endtask

    task automatic model_step();
        beat_t e;
        bit    push, close, pop;
        push  = 0;
        close = 0;
        e     = '{1'b0, 1'b0, 24'd0};
        pop   = (mq.size() != 0) && m_axis_tready;
        if (m_pv && (falign || lalign)) begin
            push = 1; close = 1; e = '{m_ps, 1'b1, m_pd};
        end else if (m_pv && idata_vld) begin
            push = 1; e = '{m_ps, 1'b0, m_pd};
        end
        if (close && (falign || (hactive != 0 && m_cnt != int'(hactive))))
            m_err = 1;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1;
        end
        if (idata_vld) begin
            m_ps = m_sf | falign; m_pd = idata; m_pv = 1; m_sf = 0;
        end else begin
            if (close) m_pv = 0;
            if (falign) m_sf = 1;
        end
        if (close) m_cnt = idata_vld ? 1 : 0;
        else if (idata_vld && m_cnt < 65535) m_cnt++;
        m_fd = ealign;
    endtask

    task automatic check_outputs();
        chk("tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
        if (mq.size() != 0)
            chk("beat", {6'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                {6'd0, mq[0].u, mq[0].l, mq[0].d});
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("line_len_err", 32'(line_len_err), 32'(m_err));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic tick();
        if (m_axis_tvalid && m_axis_tready)
            cap.push_back('{m_axis_tuser, m_axis_tlast, m_axis_tdata});
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic cyc(input logic fa, input logic la, input logic ea,
                       input logic v, input logic [23:0] d);
        falign = fa; lalign = la; ealign = ea; idata_vld = v; idata = d;
        tick();
        falign = 0; lalign = 0; ealign = 0; idata_vld = 0; idata = '0;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        m_axis_tready = 1;
        while ((m_axis_tvalid || mq.size() != 0) && n < max) begin
            tick();
            n++;
        end
        chk("drain_bound", 32'(n < max), 32'd1);
    endtask

    task automatic check_beats(input string name, input beat_t exp[$]);
        chk({name, "_count"}, 32'(cap.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            chk(name, {6'd0, cap[i].u, cap[i].l, cap[i].d},
                {6'd0, exp[i].u, exp[i].l, exp[i].d});
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_flags", {29'd0, overflow, line_len_err, frame_done}, 32'd0);
        @(negedge clock);
        rst_n = 1;
        cap.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  stim[11];
        beat_t exp[$];
        beat_t t1[$];

        // Two 4-pixel lines of one frame
        stim[0] = '{1'b1, 1'b0, 1'b0, 24'd0};
        for (int i = 0; i < 4; i++) begin
            stim[1 + i] = '{1'b0, 1'b0, 1'b1, 24'(i + 1)};
            stim[6 + i] = '{1'b0, 1'b0, 1'b1, 24'(i + 5)};
        end
        stim[5]  = '{1'b0, 1'b1, 1'b0, 24'd0};
        stim[10] = '{1'b0, 1'b1, 1'b0, 24'd0};
        for (int i = 1; i <= 8; i++)
            t1.push_back('{logic'(i == 1), logic'(i == 4 || i == 8), 24'(i)});

        model_reset();
        do_reset();

        // 1: basic frame with tready high
        hactive = 16'd4;
        m_axis_tready = 1;
        foreach (stim[i]) cyc(stim[i].fa, stim[i].la, 1'b0, stim[i].v, stim[i].d);
        drain(40);
        check_beats("t1_beat", t1);
        chk("t1_flags", {30'd0, overflow, line_len_err}, 32'd0);

        // 2: same frame behind a 20-cycle stall
        do_reset();
        m_axis_tready = 0;
        foreach (stim[i]) cyc(stim[i].fa, stim[i].la, 1'b0, stim[i].v, stim[i].d);
        for (int i = 0; i < 9; i++) tick();
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_tdata_held", 32'(m_axis_tdata), 32'd1);
        drain(40);
        exp.delete();
        for (int i = 0; i < DEPTH; i++) exp.push_back(t1[i]);
        check_beats("t2_beat", exp);

        // 3: falign with first pixel, lalign with next line's first pixel
        do_reset();
        cyc(1, 0, 0, 1, 24'h11);
        cyc(0, 0, 0, 1, 24'h12);
        cyc(0, 0, 0, 1, 24'h13);
        cyc(0, 0, 0, 1, 24'h14);
        cyc(0, 1, 0, 1, 24'h21);
        cyc(0, 0, 0, 1, 24'h22);
        cyc(0, 0, 0, 1, 24'h23);
        cyc(0, 0, 0, 1, 24'h24);
        cyc(0, 1, 0, 0, 24'h0);
        drain(40);
        exp.delete();
        exp.push_back('{1, 0, 24'h11}); exp.push_back('{0, 0, 24'h12});
        exp.push_back('{0, 0, 24'h13}); exp.push_back('{0, 1, 24'h14});
        exp.push_back('{0, 0, 24'h21}); exp.push_back('{0, 0, 24'h22});
        exp.push_back('{0, 0, 24'h23}); exp.push_back('{0, 1, 24'h24});
        check_beats("t3_beat", exp);
        chk("t3_len_err", 32'(line_len_err), 32'd0);

        // 4: short line
        do_reset();
        cyc(1, 0, 0, 0, 24'h0);
        cyc(0, 0, 0, 1, 24'h31);
        cyc(0, 0, 0, 1, 24'h32);
        cyc(0, 0, 0, 1, 24'h33);
        cyc(0, 1, 0, 0, 24'h0);
        drain(40);
        exp.delete();
        exp.push_back('{1, 0, 24'h31}); exp.push_back('{0, 0, 24'h32});
        exp.push_back('{0, 1, 24'h33});
        check_beats("t4_beat", exp);
        chk("t4_len_err", 32'(line_len_err), 32'd1);

        // 5: new frame while a pixel is still pending
        do_reset();
        cyc(1, 0, 0, 0, 24'h0);
        cyc(0, 0, 0, 1, 24'h51);
        cyc(0, 0, 0, 1, 24'h52);
        cyc(1, 0, 0, 0, 24'h0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 24'h60 + 24'(i));
        cyc(0, 1, 0, 0, 24'h0);
        drain(40);
        exp.delete();
        exp.push_back('{1, 0, 24'h51}); exp.push_back('{0, 1, 24'h52});
        exp.push_back('{1, 0, 24'h61}); exp.push_back('{0, 0, 24'h62});
        exp.push_back('{0, 0, 24'h63}); exp.push_back('{0, 1, 24'h64});
        check_beats("t5_beat", exp);
        chk("t5_len_err", 32'(line_len_err), 32'd1);

        // 6: reset mid-line with data queued, then a clean frame
        do_reset();
        m_axis_tready = 0;
        cyc(1, 0, 0, 0, 24'h0);
        for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 1, 24'h70 + 24'(i));
        chk("t6_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
        do_reset();
        m_axis_tready = 1;
        cyc(1, 0, 0, 0, 24'h0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 24'h80 + 24'(i));
        cyc(0, 1, 0, 0, 24'h0);
        cyc(0, 0, 1, 0, 24'h0);
        chk("t6_frame_done", 32'(frame_done), 32'd1);
        cyc(0, 0, 0, 0, 24'h0);
        chk("t6_frame_done_pulse", 32'(frame_done), 32'd0);
        drain(40);
        exp.delete();
        exp.push_back('{1, 0, 24'h81}); exp.push_back('{0, 0, 24'h82});
        exp.push_back('{0, 0, 24'h83}); exp.push_back('{0, 1, 24'h84});
        check_beats("t6_beat", exp);
        chk("t6_flags", {30'd0, overflow, line_len_err}, 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0: hactive = 16'd0;
                    1: hactive = 16'd3;
                    default: hactive = 16'd4;
                endcase
            end
            m_axis_tready = ($urandom_range(0, 99) < 75);
            cyc(logic'($urandom_range(0, 99) < 3),
                logic'($urandom_range(0, 99) < 15),
                logic'($urandom_range(0, 99) < 2),
                logic'($urandom_range(0, 99) < 60),
                24'($urandom));
        end
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
